// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter: id-width helper, pointer
// advance rule and bit layout of the registered read-response record.
package bram_arb_pkg;

    // Width of a requester index; never below one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Round-robin pointer after a grant to requester id.
    function automatic int rr_next(input int id, input int n);
        return (id + 1) % n;
    endfunction

    // Pending read-response record: {id, vld, oor}.
    localparam int RSP_OOR_BIT = 0;
    localparam int RSP_VLD_BIT = 1;
    localparam int RSP_ID_LSB  = 2;

    function automatic int rsp_w(input int id_w);
        return id_w + RSP_ID_LSB;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter. With BRAM_ARB_LOCK_EN
// defined the bus carries an extra per-requester lock request.
interface bram_port_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*AWIDTH-1:0] req_addr;
    logic [N_REQ*DWIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]       rsp_rdata;
    logic                    rsp_err;
`ifdef BRAM_ARB_LOCK_EN
    logic [N_REQ-1:0]        req_lock;

    modport master (output req_valid, req_we, req_addr, req_wdata, req_lock,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_lock,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
`endif
endinterface

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: first requester at or after the
// pointer (wrapping) wins.
module bram_arb_rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_id,
    output logic             o_any
);

    // Scan from the pointer, stop at the first active request.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % N_REQ;
            if (!o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among N_REQ requesters with round-robin grant and a
// fixed one-cycle read return. Optional macro BRAM_ARB_LOCK_EN adds a
// per-requester lock that holds the port for consecutive transfers.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 3840
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_port_arbiter_if.slave   bus,
    output logic                 bram_ce,
    output logic                 bram_we,
    output logic [AWIDTH-1:0]    bram_addr,
    output logic [DWIDTH-1:0]    bram_d,
    input  logic [DWIDTH-1:0]    bram_q
);
    localparam int ID_W  = clog2_min1(N_REQ);
    localparam int RSP_W = rsp_w(ID_W);
    // One extra bit so MEM_SIZE == 2**AWIDTH is representable.
    localparam logic [AWIDTH:0] MEM_LIM = (AWIDTH+1)'(MEM_SIZE);

    logic [N_REQ-1:0]  w_elig, w_gnt;
    logic [ID_W-1:0]   w_gid, r_ptr, w_ptr_nxt;
    logic              w_any, w_we, w_oor, r_err;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_wd;
    logic [RSP_W-1:0]  w_pend_nxt, r_pend;
`ifdef BRAM_ARB_LOCK_EN
    logic              w_lock, r_locked;
    logic [ID_W-1:0]   r_lock_own;
`endif

    // Eligible requesters: none in reset, only the owner while locked.
    always_comb begin
        w_elig = rst_n ? bus.req_valid : '0;
`ifdef BRAM_ARB_LOCK_EN
        if (r_locked) w_elig = w_elig & (N_REQ'(1) << r_lock_own);
`endif
    end

    bram_arb_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .i_req    (w_elig),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gid),
        .o_any    (w_any)
    );

    // Select the granted requester's command; all zero when idle.
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        w_wd   = '0;
`ifdef BRAM_ARB_LOCK_EN
        w_lock = 1'b0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_we   = bus.req_we[i];
                w_addr = bus.req_addr[i*AWIDTH +: AWIDTH];
                w_wd   = bus.req_wdata[i*DWIDTH +: DWIDTH];
`ifdef BRAM_ARB_LOCK_EN
                w_lock = bus.req_lock[i];
`endif
            end
        end
    end

    assign w_oor         = w_any && ({1'b0, w_addr} >= MEM_LIM);
    assign w_ptr_nxt     = ID_W'(rr_next(int'(w_gid), N_REQ));
    assign bus.req_ready = w_gnt;
    // Out-of-range transfers are accepted but never reach the BRAM.
    assign bram_ce       = w_any && !w_oor;
    assign bram_we       = bram_ce && w_we;
    assign bram_addr     = w_addr;
    assign bram_d        = w_wd;

    // Round-robin pointer; frozen while a lock is being held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
`ifdef BRAM_ARB_LOCK_EN
            if (!w_lock) r_ptr <= w_ptr_nxt;
`else
            r_ptr <= w_ptr_nxt;
`endif
        end
    end

`ifdef BRAM_ARB_LOCK_EN
    // Lock is taken or released by each transfer of the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked   <= 1'b0;
            r_lock_own <= '0;
        end else if (w_any) begin
            r_locked <= w_lock;
            if (w_lock) r_lock_own <= w_gid;
        end
    end
`endif

    // Record of this cycle's granted read; all zero otherwise.
    always_comb begin
        w_pend_nxt = '0;
        if (w_any && !w_we) begin
            w_pend_nxt[RSP_VLD_BIT]           = 1'b1;
            w_pend_nxt[RSP_OOR_BIT]           = w_oor;
            w_pend_nxt[RSP_ID_LSB +: ID_W]    = w_gid;
        end
    end

    // Pending-response pipe and out-of-range error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_err  <= w_oor;
        end
    end

    // Steer the BRAM return to the requester; zero data unless a valid in-range read.
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++)
            bus.rsp_valid[i] = r_pend[RSP_VLD_BIT] && (r_pend[RSP_ID_LSB +: ID_W] == ID_W'(i));
        bus.rsp_rdata = (r_pend[RSP_VLD_BIT] && !r_pend[RSP_OOR_BIT]) ? bram_q : '0;
    end

    assign bus.rsp_err = r_err;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter (N_REQ=2) with a 1-cycle BRAM model.
module tb_bram_port_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MS = 3840;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.N_REQ(N), .DWIDTH(DW), .AWIDTH(AW)) bif();
    logic          bram_ce, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_d, bram_q;

    bram_port_arbiter #(.N_REQ(N), .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif),
        .bram_ce(bram_ce), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_d(bram_d), .bram_q(bram_q)
    );

    // BRAM model: registered read, one access per cycle.
    logic [DW-1:0] mem [0:MS-1];
    always @(posedge clk) begin
        if (bram_ce && int'(bram_addr) < MS) begin
            if (bram_we) mem[bram_addr] <= bram_d;
            else         bram_q <= mem[bram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] ref_mem [0:15];

    task automatic drive(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit lk);
        bif.req_valid[i]           = v;
        bif.req_we[i]              = we;
        bif.req_addr[i*AW +: AW]   = a;
        bif.req_wdata[i*DW +: DW]  = d;
`ifdef BRAM_ARB_LOCK_EN
        bif.req_lock[i]            = lk;
`else
        if (lk) bif.req_we[i] = we;
`endif
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b0, 12'h010, '0, 1'b0);
        drive(1, 1'b1, 1'b0, 12'h020, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bif.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", bif.req_ready); end
        n_tests++; if (bram_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b exp 0", bram_ce); end
        n_tests++; if (bram_addr !== '0 || bram_d !== '0 || bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus got addr %h d %h we %b exp 0", bram_addr, bram_d, bram_we); end
        @(posedge clk); #1;
        n_tests++; if (bif.rsp_valid !== 2'b00 || bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got %b err %b exp 00/0", bif.rsp_valid, bif.rsp_err); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (bif.req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant got %b exp 01", bif.req_ready); end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_contention();
        logic [DW-1:0] v0, v1;
        do_reset();
        v0 = $urandom; v1 = $urandom;
        drive(0, 1'b1, 1'b1, 12'h010, v0, 1'b0);
        drive(1, 1'b1, 1'b1, 12'h020, v1, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        // pointer is back at 0 after r0 then r1
        drive(0, 1'b1, 1'b0, 12'h010, '0, 1'b0);
        drive(1, 1'b1, 1'b0, 12'h020, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            #1;
            n_tests++; if (bif.req_ready !== 2'(1 << e) || bram_ce !== 1'b1) begin n_fail++; $display("FAIL contention_grant k=%0d got %b ce %b exp %b", k, bif.req_ready, bram_ce, 2'(1 << e)); end
            @(posedge clk); #1;
            n_tests++; if (bif.rsp_valid !== 2'(1 << e) || bif.rsp_rdata !== (e == 0 ? v0 : v1)) begin n_fail++; $display("FAIL contention_rsp k=%0d got %b %h exp %b %h", k, bif.rsp_valid, bif.rsp_rdata, 2'(1 << e), (e == 0 ? v0 : v1)); end
        end
        idle_all();
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        do_reset();
        drive(1, 1'b1, 1'b1, 12'h005, 32'hDEADBEEF, 1'b0);
        #1;
        n_tests++; if (bif.req_ready !== 2'b10 || bram_ce !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 12'h005 || bram_d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bus got rdy %b ce %b we %b a %h d %h exp 10 1 1 005 deadbeef", bif.req_ready, bram_ce, bram_we, bram_addr, bram_d); end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(0, 1'b1, 1'b0, 12'h005, '0, 1'b0);
        n_tests++; if (bif.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rsp got %b exp 00", bif.rsp_valid); end
        @(posedge clk); #1;
        idle_all();
        n_tests++; if (bif.rsp_valid !== 2'b01 || bif.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_readback got %b %h exp 01 deadbeef", bif.rsp_valid, bif.rsp_rdata); end
        @(posedge clk); #1;
        n_tests++; if (bif.rsp_valid !== 2'b00 || bif.rsp_rdata !== '0) begin n_fail++; $display("FAIL idle_rdata got %b %h exp 00 0", bif.rsp_valid, bif.rsp_rdata); end
    endtask

    task automatic test_oor();
        do_reset();
        drive(0, 1'b1, 1'b1, 12'hF00, 32'h12345678, 1'b0);
        #1;
        n_tests++; if (bif.req_ready !== 2'b01 || bram_ce !== 1'b0 || bram_we !== 1'b0) begin n_fail++; $display("FAIL oor_wr got rdy %b ce %b we %b exp 01 0 0", bif.req_ready, bram_ce, bram_we); end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b1, 1'b0, 12'hF00, '0, 1'b0);
        n_tests++; if (bif.rsp_err !== 1'b1 || bif.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL oor_wr_err got err %b v %b exp 1 00", bif.rsp_err, bif.rsp_valid); end
        #1;
        n_tests++; if (bif.req_ready !== 2'b10 || bram_ce !== 1'b0) begin n_fail++; $display("FAIL oor_rd got rdy %b ce %b exp 10 0", bif.req_ready, bram_ce); end
        @(posedge clk); #1;
        idle_all();
        n_tests++; if (bif.rsp_valid !== 2'b10 || bif.rsp_rdata !== '0 || bif.rsp_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_rsp got %b %h err %b exp 10 0 1", bif.rsp_valid, bif.rsp_rdata, bif.rsp_err); end
        @(posedge clk); #1;
        n_tests++; if (bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got %b exp 0", bif.rsp_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1'b1, 1'b0, 12'h010, '0, 1'b0);
        #1;
        n_tests++; if (bif.req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_grant got %b exp 01", bif.req_ready); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bif.req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready got %b exp 00", bif.req_ready); end
        @(posedge clk); #1;
        n_tests++; if (bif.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rsp got %b exp 00", bif.rsp_valid); end
        idle_all();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_tests++; if (bif.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_after k=%0d got %b exp 00", k, bif.rsp_valid); end
        end
    endtask

    task automatic test_lock();
        int c;
        do_reset();
        c = 0;
        drive(1, 1'b1, 1'b0, 12'h020, '0, 1'b0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            int e;
            drive(0, c < 4, 1'b0, 12'h010, '0, c < 3);
`ifdef BRAM_ARB_LOCK_EN
            e = (cyc < 4) ? 0 : 1;
`else
            e = cyc % 2;
`endif
            #1;
            n_tests++; if (bif.req_ready !== 2'(1 << e)) begin n_fail++; $display("FAIL lock_grant cyc=%0d got %b exp %b", cyc, bif.req_ready, 2'(1 << e)); end
            if (bif.req_ready[0]) c++;
            @(posedge clk); #1;
            n_tests++; if (bif.rsp_valid !== 2'(1 << e)) begin n_fail++; $display("FAIL lock_rsp cyc=%0d got %b exp %b", cyc, bif.rsp_valid, 2'(1 << e)); end
        end
        idle_all();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int            m_ptr, g;
        bit            pv [N];
        bit            pwe[N];
        logic [AW-1:0] pa [N];
        logic [DW-1:0] pd [N];
        logic [N-1:0]  ev, er;
        logic [DW-1:0] erd;
        bit            eerr, oor;
        do_reset();
        // seed the 16 low words through requester 0
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            drive(0, 1'b1, 1'b1, AW'(a), ref_mem[a], 1'b0);
            @(posedge clk); #1;
        end
        idle_all();
        m_ptr = 1;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom % 3) != 0) begin
                    pv[i]  = 1'b1;
                    pwe[i] = 1'($urandom % 2);
                    pa[i]  = (($urandom % 8) == 0) ? AW'(MS + ($urandom % 256)) : AW'($urandom % 16);
                    pd[i]  = $urandom;
                end
                drive(i, pv[i], pwe[i], pa[i], pd[i], 1'b0);
            end
            #1;
            g = -1;
            for (int k = 0; k < N; k++) if (g < 0 && pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            er = '0; ev = '0; erd = '0; eerr = 1'b0;
            if (g >= 0) er[g] = 1'b1;
            n_tests++; if (bif.req_ready !== er) begin n_fail++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, bif.req_ready, er); end
            if (g >= 0) begin
                oor = int'(pa[g]) >= MS;
                n_tests++; if (bram_ce !== !oor || (!oor && (bram_we !== pwe[g] || bram_addr !== pa[g] || (pwe[g] && bram_d !== pd[g])))) begin n_fail++; $display("FAIL rand_bus cyc=%0d got ce %b we %b a %h d %h exp ce %b we %b a %h d %h", cyc, bram_ce, bram_we, bram_addr, bram_d, !oor, pwe[g], pa[g], pd[g]); end
                m_ptr = (g + 1) % N;
                eerr  = oor;
                if (!pwe[g]) begin ev[g] = 1'b1; erd = oor ? '0 : ref_mem[pa[g][3:0]]; end
                else if (!oor) ref_mem[pa[g][3:0]] = pd[g];
                pv[g] = 1'b0;
            end
            @(posedge clk); #1;
            n_tests++; if (bif.rsp_valid !== ev || bif.rsp_rdata !== erd || bif.rsp_err !== eerr) begin n_fail++; $display("FAIL rand_rsp cyc=%0d got %b %h err %b exp %b %h err %b", cyc, bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, ev, erd, eerr); end
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        rst_n = 1'b0;
        test_reset();
        test_contention();
        test_write_read();
        test_oor();
        test_reset_mid();
        test_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
